hamming_secded_decoder_pipe: RTL and testbench

- Parametrised, pipelined successor of the combinational 8-bit Hamming SECDED decoder.
- Decodes a codeword carrying DATA_W data bits: corrects single-bit errors and flags double-bit (uncorrectable) errors.
- Uses a valid/ready handshake on both sides, so it can sit between the UART/LED front end and the Tang 9K consumer logic with backpressure.
- Holds saturating single-error and double-error counters for board-level diagnostics.

---
 rtl/hamming_secded_decoder_pipe.sv | 131 +++++++++++++
 tb/tb_hamming_secded_decoder_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_decoder_pipe.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready handshake on both sides
// and saturating single/double error counters for board-level diagnostics.
module hamming_secded_decoder_pipe #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16,
    localparam int P      = (DATA_W <= 1)  ? 2 :
                            (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 : 6,
    localparam int CODE_W = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_single_err,
    output logic              out_double_err,
    input  logic              clr_counters,
    output logic [CNT_W-1:0]  single_cnt,
    output logic [CNT_W-1:0]  double_cnt
);

    localparam logic [P:0] MAX_SYN = (P+1)'(CODE_W - 1);

    function automatic logic [P-1:0] calc_syn(input logic [CODE_W-1:0] c);
        logic [P-1:0] s;
        s = '0;
        for (int i = 0; i < CODE_W - 1; i++) begin
            if (c[i]) s ^= P'(i + 1);
        end
        return s;
    endfunction

    // Data bits occupy every non-power-of-two Hamming position, d0 at the lowest.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int pos = 1; pos < CODE_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[j] = c[pos-1];
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              vld_p1;
    logic [CODE_W-1:0] code_p1;
    logic [P-1:0]      syn_p1;
    logic              ov_p1;
    logic              en1, en2;
    logic [CODE_W-1:0] flip_c;
    logic [DATA_W-1:0] data_c;
    logic              single_c, double_c;
    logic              xfer_out;

    assign en2      = !out_valid || out_ready;
    assign en1      = !vld_p1 || en2;
    assign in_ready = en1;
    assign xfer_out = out_valid && out_ready;

    // Stage 1: capture codeword, syndrome and overall parity
    always_ff @(posedge clk) begin
        if (en1 && in_valid) begin
            code_p1 <= in_code;
            syn_p1  <= calc_syn(in_code);
            ov_p1   <= ^in_code;
        end
    end

    // Stage 2: classify the error and build the corrected data
    always_comb begin
        flip_c   = '0;
        single_c = 1'b0;
        double_c = 1'b0;
        if (ov_p1) begin
            if (syn_p1 == '0) begin
                single_c = 1'b1;
            end else if ({1'b0, syn_p1} <= MAX_SYN) begin
                single_c = 1'b1;
                flip_c   = CODE_W'(1) << (syn_p1 - P'(1));
            end else begin
                double_c = 1'b1;
            end
        end else if (syn_p1 != '0) begin
            double_c = 1'b1;
        end
        data_c = extract_data(code_p1 ^ flip_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1         <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_single_err <= 1'b0;
            out_double_err <= 1'b0;
            single_cnt     <= '0;
            double_cnt     <= '0;
        end else begin
            if (en1) vld_p1 <= in_valid;
            if (en2) begin
                out_valid <= vld_p1;
                if (vld_p1) begin
                    out_data       <= data_c;
                    out_single_err <= single_c;
                    out_double_err <= double_c;
                end
            end
            // Clear wins over a same-cycle counted transfer.
            if (clr_counters) begin
                single_cnt <= '0;
                double_cnt <= '0;
            end else if (xfer_out) begin
                if (out_single_err) single_cnt <= sat_inc(single_cnt);
                if (out_double_err) double_cnt <= sat_inc(double_cnt);
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_decoder_pipe.sv
// Scoreboard bench: DATA_W=4 with 2-bit counters for saturation, plus a DATA_W=8 instance
// for the shortened-code out-of-range syndrome case.
module tb_hamming_secded_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_code;
    logic [3:0] out_data;
    logic       out_single_err, out_double_err, clr_counters;
    logic [1:0] single_cnt, double_cnt;

    logic        w_in_valid, w_in_ready, w_out_valid;
    logic [12:0] w_in_code;
    logic [7:0]  w_out_data;
    logic        w_single, w_double;
    logic [15:0] w_single_cnt, w_double_cnt;

    int errors = 0;
    int checks = 0;
    logic [5:0] exp_q[$];
    logic       hold_prev = 1'b0;
    logic [5:0] held;

    always #5 clk = ~clk;

    hamming_secded_decoder_pipe #(.DATA_W(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_single_err(out_single_err), .out_double_err(out_double_err),
        .clr_counters(clr_counters), .single_cnt(single_cnt), .double_cnt(double_cnt)
    );

    hamming_secded_decoder_pipe #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_code(w_in_code),
        .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data),
        .out_single_err(w_single), .out_double_err(w_double),
        .clr_counters(1'b0), .single_cnt(w_single_cnt), .double_cnt(w_double_cnt)
    );

    // Output monitor: pops the scoreboard on every transfer and checks stalled outputs hold.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checks++;
                if (!out_valid || {out_data, out_single_err, out_double_err} !== held) begin
                    errors++;
                    $display("FAIL hold: got valid=%0b out=%h, want valid=1 out=%h",
                             out_valid, {out_data, out_single_err, out_double_err}, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got out=%h, want no output",
                             {out_data, out_single_err, out_double_err});
                end else begin
                    logic [5:0] e;
                    e = exp_q.pop_front();
                    if ({out_data, out_single_err, out_double_err} !== e) begin
                        errors++;
                        $display("FAIL scoreboard: got data=%h s=%0b d=%0b, want data=%h s=%0b d=%0b",
                                 out_data, out_single_err, out_double_err, e[5:2], e[1], e[0]);
                    end
                end
            end
            hold_prev = out_valid && !out_ready;
            held      = {out_data, out_single_err, out_double_err};
        end
    end

    // All tasks start and end just after a rising edge.
    task automatic push_word(input logic [7:0] code, input logic [3:0] d, input logic s, input logic dd);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_code  = code;
        for (int k = 0; k < 30 && !acc; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                exp_q.push_back({d, s, dd});
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: got in_ready=0 for 30 cycles, want 1");
        end
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain: got %0d words outstanding, want 0", exp_q.size());
        end
    endtask

    task automatic check_cnt(input string name, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_single_err !== 1'b0 ||
            out_double_err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%0b d=%h s=%0b dd=%0b rdy=%0b, want v=0 d=0 s=0 dd=0 rdy=1",
                     out_valid, out_data, out_single_err, out_double_err, in_ready);
        end
        check_cnt("reset_single_cnt", single_cnt, 2'd0);
        check_cnt("reset_double_cnt", double_cnt, 2'd0);
    endtask

    task automatic test_clean();
        push_word(8'h55, 4'hB, 1'b0, 1'b0);
        push_word(8'h33, 4'h6, 1'b0, 1'b0);
        wait_drain();
        check_cnt("clean_single_cnt", single_cnt, 2'd0);
    endtask

    task automatic test_single();
        push_word(8'h45, 4'hB, 1'b1, 1'b0);
        wait_drain();
        check_cnt("single_cnt_after_data_err", single_cnt, 2'd1);
        push_word(8'hD5, 4'hB, 1'b1, 1'b0);
        wait_drain();
        check_cnt("single_cnt_after_parity_err", single_cnt, 2'd2);
    endtask

    task automatic test_double();
        push_word(8'h56, 4'hB, 1'b0, 1'b1);
        wait_drain();
        check_cnt("double_cnt", double_cnt, 2'd1);
        check_cnt("single_cnt_unchanged", single_cnt, 2'd2);
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes[5];
        logic [5:0] exps[5];
        int idx;
        logic saw_stall;
        codes = '{8'h33, 8'h13, 8'h55, 8'h56, 8'h45};
        exps  = '{{4'h6, 2'b00}, {4'h6, 2'b10}, {4'hB, 2'b00}, {4'hB, 2'b01}, {4'hB, 2'b10}};
        idx = 0;
        saw_stall = 1'b0;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = 1'b1;
            in_code   = codes[idx];
            @(negedge clk);
            if (c == 4) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready: got in_ready=%0b, want 0", in_ready);
                end
            end
            if (!in_ready) saw_stall = 1'b1;
            if (in_ready) begin
                exp_q.push_back(exps[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        checks++;
        if (idx != 5 || !saw_stall) begin
            errors++;
            $display("FAIL stream: got accepted=%0d stall=%0b, want accepted=5 stall=1", idx, saw_stall);
        end
    endtask

    task automatic test_counters();
        logic seen;
        clr_counters = 1'b1;
        @(posedge clk);
        #1;
        clr_counters = 1'b0;
        check_cnt("clr_single_cnt", single_cnt, 2'd0);
        check_cnt("clr_double_cnt", double_cnt, 2'd0);
        for (int i = 0; i < 5; i++) push_word(8'h45, 4'hB, 1'b1, 1'b0);
        wait_drain();
        check_cnt("sat_single_cnt", single_cnt, 2'd3);
        push_word(8'hD5, 4'hB, 1'b1, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                clr_counters = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        clr_counters = 1'b0;
        check_cnt("clr_priority_single_cnt", single_cnt, 2'd0);
        wait_drain();
    endtask

    task automatic wide_check(input string name, input logic [12:0] code,
                              input logic [7:0] d, input logic s, input logic dd);
        logic got;
        checks++;
        if (w_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: got %0b, want 1", name, w_in_ready);
        end
        w_in_valid = 1'b1;
        w_in_code  = code;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            if (w_out_valid) begin
                got = 1'b1;
                checks++;
                if ({w_out_data, w_single, w_double} !== {d, s, dd}) begin
                    errors++;
                    $display("FAIL %s: got data=%h s=%0b d=%0b, want data=%h s=%0b d=%0b",
                             name, w_out_data, w_single, w_double, d, s, dd);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got no out_valid, want one", name);
        end
    endtask

    task automatic test_wide();
        wide_check("wide_syn14", 13'h0C1, 8'h08, 1'b0, 1'b1);
        wide_check("wide_single_d7", 13'h800, 8'h00, 1'b1, 1'b0);
        wide_check("wide_double", 13'h005, 8'h01, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midstream();
        push_word(8'h56, 4'hB, 1'b0, 1'b1);
        wait_drain();
        check_cnt("pre_reset_double_cnt", double_cnt, 2'd1);
        out_ready = 1'b0;
        push_word(8'h45, 4'hB, 1'b1, 1'b0);
        push_word(8'h56, 4'hB, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: got v=%0b rdy=%0b, want v=0 rdy=1", out_valid, in_ready);
        end
        check_cnt("post_reset_double_cnt", double_cnt, 2'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_word: got out_valid=1 at cycle %0d, want 0", k);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_code = 8'h00;
        out_ready = 1'b1;
        clr_counters = 1'b0;
        w_in_valid = 1'b0;
        w_in_code = 13'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_back_to_back();
        test_counters();
        test_wide();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
